// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// Shared AHB encodings and sizing for the round-robin burst arbiter.
// Configuration macro ARB_BURST_HOLD_EN selects burst-hold support in the top.
package ahb_rr_burst_arbiter_pkg;

   localparam int NUM_PORTS = 4;
   localparam int PORT_W    = 2;
   localparam int BEAT_W    = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Beats still owed after the NONSEQ of a fixed-length burst; 0 = nothing to hold.
   function automatic logic [BEAT_W-1:0] burst_beats_left(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_beats_left = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  burst_beats_left = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: burst_beats_left = 4'd15;
         default:                      burst_beats_left = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_prio_pick.sv
// Combinational 4-way round-robin picker: first requester after last_grant, wrapping.
// Zero latency, no backpressure; the previous owner is the lowest-priority candidate.
module ahb_rr_prio_pick
   import ahb_rr_burst_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    last_grant,
   output logic [PORT_W-1:0]    winner,
   output logic                 any_req
);

   logic [PORT_W-1:0] idx;

   // Walk from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      winner  = last_grant;
      any_req = |req;
      idx     = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = last_grant + PORT_W'(i);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// AHB shared-slave round-robin arbiter; grant registered, visible one cycle after the deciding edge.
// HREADYM low freezes all state; macro ARB_BURST_HOLD_EN keeps fixed-length bursts unbroken.
module ahb_rr_burst_arbiter
   import ahb_rr_burst_arbiter_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       req_port0,
   input  logic       req_port1,
   input  logic       req_port2,
   input  logic       req_port3,
   input  logic       HREADYM,
   input  logic       HSELM,
   input  logic [1:0] HTRANSM,
   input  logic [2:0] HBURSTM,
   input  logic       HMASTLOCKM,
   output logic [1:0] addr_in_port,
   output logic       no_port
);

   logic [NUM_PORTS-1:0] req;
   logic [PORT_W-1:0]    last_grant;
   logic [PORT_W-1:0]    winner;
   logic                 any_req;
   logic                 hold;

   assign req = {req_port3, req_port2, req_port1, req_port0};

   ahb_rr_prio_pick u_pick (
      .req        (req),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

`ifdef ARB_BURST_HOLD_EN
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beat_cnt_next;

   // Only meaningful when HREADYM is high; the register ignores it otherwise.
   always_comb begin
      beat_cnt_next = beat_cnt;
      if (!HSELM) begin
         beat_cnt_next = '0;
      end else begin
         case (HTRANSM)
            HTRANS_IDLE:   beat_cnt_next = '0;
            HTRANS_BUSY:   beat_cnt_next = beat_cnt;
            HTRANS_NONSEQ: beat_cnt_next = burst_beats_left(HBURSTM);
            HTRANS_SEQ:    beat_cnt_next = (beat_cnt != '0) ? beat_cnt - 4'd1 : '0;
            default:       beat_cnt_next = beat_cnt;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         beat_cnt <= '0;
      end else if (HREADYM) begin
         beat_cnt <= beat_cnt_next;
      end
   end

   assign hold = HMASTLOCKM | (beat_cnt_next != '0);
`else
   logic unused_burst_inputs;
   assign unused_burst_inputs = ^{HSELM, HTRANSM, HBURSTM};
   assign hold = HMASTLOCKM;
`endif

   // With nobody requesting, the last owner is remembered so rotation resumes from it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_in_port <= 2'd0;
         no_port      <= 1'b1;
         last_grant   <= 2'd3;
      end else if (HREADYM && !hold) begin
         if (any_req) begin
            addr_in_port <= winner;
            no_port      <= 1'b0;
            last_grant   <= winner;
         end else begin
            no_port      <= 1'b1;
         end
      end
   end

endmodule
